// File: rtl/trisc_pkg.sv
// Shared TRISC definitions: controller states, opcode map and instruction-field helper.
// No logic of its own; no latency and no backpressure.
package trisc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_STA  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_JC   = 4'hA;
   localparam logic [3:0] OP_INC  = 4'hB;
   localparam logic [3:0] OP_CLA  = 4'hC;
   localparam logic [3:0] OP_NOTA = 4'hD;
   localparam logic [3:0] OP_NOP2 = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Opcode sits directly above the w-bit operand in an instruction word.
   function automatic logic [3:0] opcode_field(input logic [31:0] word, input int w);
      opcode_field = 4'(word >> w);
   endfunction

endpackage

// File: rtl/trisc_alu_param.sv
// TRISC accumulator ALU: result plus carry, and which of ACC/Zero/Carry the opcode updates.
// Purely combinational; no backpressure.
module trisc_alu_param
   import trisc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] m,
   input  logic [3:0]   op,
   output logic [W-1:0] result,
   output logic         carryOut,
   output logic         carryWe,
   output logic         zeroWe
);

   logic [W:0] sum;

   // zeroWe doubles as the accumulator write enable: exactly the ACC-writing opcodes touch Zero.
   always_comb begin
      result   = acc;
      carryOut = 1'b0;
      carryWe  = 1'b0;
      zeroWe   = 1'b0;
      sum      = '0;
      case (op)
         OP_LDA, OP_LDI: begin
            result = m;
            zeroWe = 1'b1;
         end
         OP_ADD: begin
            sum      = {1'b0, acc} + {1'b0, m};
            result   = sum[W-1:0];
            carryOut = sum[W];
            carryWe  = 1'b1;
            zeroWe   = 1'b1;
         end
         OP_SUB: begin
            result   = acc - m;
            carryOut = (acc < m);
            carryWe  = 1'b1;
            zeroWe   = 1'b1;
         end
         OP_AND: begin
            result = acc & m;
            zeroWe = 1'b1;
         end
         OP_OR: begin
            result = acc | m;
            zeroWe = 1'b1;
         end
         OP_INC: begin
            sum      = {1'b0, acc} + {{W{1'b0}}, 1'b1};
            result   = sum[W-1:0];
            carryOut = sum[W];
            carryWe  = 1'b1;
            zeroWe   = 1'b1;
         end
         OP_CLA: begin
            result = '0;
            zeroWe = 1'b1;
         end
         OP_NOTA: begin
            result = ~acc;
            zeroWe = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/trisc_core_param.sv
// TRISC processor core: FSM, PC/IR/ACC, flags and 2**W-word RAM with a load port.
// Three cycles per instruction; load writes take one cycle; no backpressure.
module trisc_core_param
   import trisc_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           SysClock,
   input  logic           Clear,
   input  logic           Start,
   input  logic           Mode,
   input  logic           LoadWr,
   input  logic           LoadPtrClr,
   input  logic [W+3:0]   DataIn,
   output logic [W-1:0]   PC,
   output logic [W-1:0]   ACC,
   output logic [3:0]     IR,
   output logic [W-1:0]   MAR,
   output logic [W+3:0]   MDO,
   output logic           Zero,
   output logic           Carry,
   output logic           Running,
   output logic           Halted
);

   localparam int DEPTH = 2**W;

   state_t         state;
   logic [W-1:0]   ldPtr;
   logic [W-1:0]   operand;
   logic [W+3:0]   ram [DEPTH];

   logic           idleLike;
   logic           loadMode;
   logic           ramWe;
   logic [W+3:0]   ramWd;
   logic [W-1:0]   aluM;
   logic [W-1:0]   aluResult;
   logic           aluCarry;
   logic           aluCarryWe;
   logic           aluZeroWe;

   assign idleLike = (state == IDLE) || (state == HALT);
   assign loadMode = idleLike && Mode;
   assign Running  = (state == FETCH) || (state == DECODE) || (state == EXEC);
   assign Halted   = (state == HALT);

   // In DECODE the operand register is not yet loaded, so address straight from the fetched word.
   always_comb begin
      case (state)
         FETCH:   MAR = PC;
         DECODE:  MAR = MDO[W-1:0];
         EXEC:    MAR = operand;
         default: MAR = loadMode ? ldPtr : PC;
      endcase
   end

   assign ramWe = !Clear && ((loadMode && LoadWr) || (state == EXEC && IR == OP_STA));
   assign ramWd = loadMode ? DataIn : {4'h0, ACC};
   assign aluM  = (IR == OP_LDI) ? operand : MDO[W-1:0];

   trisc_alu_param #(.W(W)) u_alu (
      .acc      (ACC),
      .m        (aluM),
      .op       (IR),
      .result   (aluResult),
      .carryOut (aluCarry),
      .carryWe  (aluCarryWe),
      .zeroWe   (aluZeroWe)
   );

   // RAM contents survive Clear.
   always_ff @(posedge SysClock) begin
      if (ramWe) begin
         ram[MAR] <= ramWd;
      end
   end

   always_ff @(posedge SysClock) begin
      if (Clear) begin
         MDO <= '0;
      end else begin
         MDO <= ram[MAR];
      end
   end

   always_ff @(posedge SysClock) begin
      if (Clear) begin
         state   <= IDLE;
         PC      <= '0;
         ACC     <= '0;
         IR      <= '0;
         ldPtr   <= '0;
         operand <= '0;
         Zero    <= 1'b0;
         Carry   <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (Mode) begin
                  if (LoadPtrClr) begin
                     ldPtr <= '0;
                  end else if (LoadWr) begin
                     ldPtr <= ldPtr + W'(1);
                  end
               end else if (Start) begin
                  PC    <= '0;
                  ACC   <= '0;
                  Zero  <= 1'b0;
                  Carry <= 1'b0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               state <= DECODE;
            end
            DECODE: begin
               IR      <= opcode_field(32'(MDO), W);
               operand <= MDO[W-1:0];
               PC      <= PC + W'(1);
               state   <= EXEC;
            end
            EXEC: begin
               if (aluZeroWe) begin
                  ACC  <= aluResult;
                  Zero <= (aluResult == '0);
               end
               if (aluCarryWe) begin
                  Carry <= aluCarry;
               end
               case (IR)
                  OP_JMP:  PC <= operand;
                  OP_JZ:   if (Zero)  PC <= operand;
                  OP_JC:   if (Carry) PC <= operand;
                  default: ;
               endcase
               state <= (IR == OP_HLT) ? HALT : FETCH;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trisc_core_param.sv
// Bench for trisc_core_param (W=4): directed scenarios with literal expectations plus
// random programs checked per instruction against an instruction-level reference model.
module tb_trisc_core_param;

   logic       clk = 1'b0;
   logic       Clear = 1'b1;
   logic       Start = 1'b0;
   logic       Mode = 1'b0;
   logic       LoadWr = 1'b0;
   logic       LoadPtrClr = 1'b0;
   logic [7:0] DataIn = 8'h00;
   logic [3:0] PC, ACC, IR, MAR;
   logic [7:0] MDO;
   logic       Zero, Carry, Running, Halted;

   int checks = 0;
   int errors = 0;

   logic [7:0] prog [16];
   logic [7:0] mem  [16];
   logic [3:0] mpc, macc;
   logic       mz, mc, mhalt;

   always #5 clk = ~clk;

   trisc_core_param #(.W(4)) dut (
      .SysClock   (clk),
      .Clear      (Clear),
      .Start      (Start),
      .Mode       (Mode),
      .LoadWr     (LoadWr),
      .LoadPtrClr (LoadPtrClr),
      .DataIn     (DataIn),
      .PC         (PC),
      .ACC        (ACC),
      .IR         (IR),
      .MAR        (MAR),
      .MDO        (MDO),
      .Zero       (Zero),
      .Carry      (Carry),
      .Running    (Running),
      .Halted     (Halted)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      Clear = 1'b1; Start = 1'b0; Mode = 1'b0; LoadWr = 1'b0; LoadPtrClr = 1'b0;
      @(negedge clk);
      Clear = 1'b0;
   endtask

   task automatic load_prog();
      @(negedge clk);
      Mode = 1'b1; LoadPtrClr = 1'b1;
      @(negedge clk);
      LoadPtrClr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         LoadWr = 1'b1; DataIn = prog[i]; mem[i] = prog[i];
         @(negedge clk);
      end
      LoadWr = 1'b0; Mode = 1'b0;
   endtask

   task automatic start_run();
      @(negedge clk);
      Mode = 1'b0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   task automatic model_reset();
      mpc = 4'h0; macc = 4'h0; mz = 1'b0; mc = 1'b0; mhalt = 1'b0;
   endtask

   // One whole instruction, straight from the ISA description.
   task automatic model_step();
      int op, a, mv, acc, t;
      op  = int'(mem[mpc][7:4]);
      a   = int'(mem[mpc][3:0]);
      mv  = int'(mem[a][3:0]);
      acc = int'(macc);
      mpc = mpc + 4'd1;
      case (op)
         1:  begin acc = mv;                               mz = (acc == 0); end
         2:  mem[a] = {4'h0, macc};
         3:  begin t = acc + mv; mc = (t > 15); acc = t % 16; mz = (acc == 0); end
         4:  begin mc = (acc < mv); acc = (acc - mv + 16) % 16; mz = (acc == 0); end
         5:  begin acc = acc & mv;                        mz = (acc == 0); end
         6:  begin acc = acc | mv;                        mz = (acc == 0); end
         7:  begin acc = a;                               mz = (acc == 0); end
         8:  mpc = 4'(a);
         9:  if (mz) mpc = 4'(a);
         10: if (mc) mpc = 4'(a);
         11: begin t = acc + 1; mc = (t > 15); acc = t % 16; mz = (acc == 0); end
         12: begin acc = 0;                               mz = 1'b1; end
         13: begin acc = 15 - acc;                        mz = (acc == 0); end
         15: mhalt = 1'b1;
         default: ;
      endcase
      macc = 4'(acc);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if ({PC, ACC, IR, MAR} !== 16'h0000) begin errors++; $display("FAIL reset_regs got %h want 0000", {PC, ACC, IR, MAR}); end
      checks++; if (MDO !== 8'h00) begin errors++; $display("FAIL reset_mdo got %h want 00", MDO); end
      checks++; if ({Zero, Carry, Running, Halted} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {Zero, Carry, Running, Halted}); end
      Clear = 1'b0;
   endtask

   task automatic test_program1();
      int n;
      do_clear();
      clear_prog();
      prog[0] = 8'h75; prog[1] = 8'h38; prog[2] = 8'h29; prog[3] = 8'hF0; prog[8] = 8'h0C;
      load_prog();
      @(negedge clk);
      Mode = 1'b0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      n = 0;
      while (!Halted && n < 40) begin @(negedge clk); n++; end
      checks++; if (n !== 12) begin errors++; $display("FAIL p1_halt_edges got %0d want 12", n); end
      checks++; if (ACC !== 4'h1) begin errors++; $display("FAIL p1_acc got %h want 1", ACC); end
      checks++; if ({Carry, Zero} !== 2'b10) begin errors++; $display("FAIL p1_flags got %b want 10", {Carry, Zero}); end
      checks++; if (dut.ram[9] !== 8'h01) begin errors++; $display("FAIL p1_ram9 got %h want 01", dut.ram[9]); end
      checks++; if (PC !== 4'h4) begin errors++; $display("FAIL p1_pc got %h want 4", PC); end
   endtask

   task automatic test_branch();
      do_clear();
      clear_prog();
      prog[0] = 8'h70; prog[1] = 8'h95; prog[2] = 8'h77; prog[3] = 8'hF0;
      prog[5] = 8'h73; prog[6] = 8'hF0;
      load_prog();
      start_run();
      cyc(12);
      checks++; if ({Halted, PC, ACC} !== {1'b1, 4'h7, 4'h3}) begin errors++; $display("FAIL br_state got H%b PC%h ACC%h want H1 PC7 ACC3", Halted, PC, ACC); end
   endtask

   task automatic test_sub_borrow();
      do_clear();
      clear_prog();
      prog[0] = 8'h72; prog[1] = 8'h4A; prog[2] = 8'hB0; prog[3] = 8'hF0; prog[10] = 8'h03;
      load_prog();
      start_run();
      cyc(6);
      checks++; if ({ACC, Carry, Zero} !== {4'hF, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_borrow got ACC%h C%b Z%b want ACCf C1 Z0", ACC, Carry, Zero); end
      cyc(3);
      checks++; if ({ACC, Carry, Zero} !== {4'h0, 1'b1, 1'b1}) begin errors++; $display("FAIL inc_wrap got ACC%h C%b Z%b want ACC0 C1 Z1", ACC, Carry, Zero); end
   endtask

   task automatic test_pc_wrap();
      do_clear();
      clear_prog();
      prog[0] = 8'h8F;
      load_prog();
      start_run();
      cyc(3);
      checks++; if (PC !== 4'hF) begin errors++; $display("FAIL wrap_jmp got %h want f", PC); end
      cyc(3);
      checks++; if (PC !== 4'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", PC); end
      do_clear();
      prog[0] = 8'hF0;
      load_prog();
      start_run();
      cyc(3);
      checks++; if ({Halted, PC} !== {1'b1, 4'h1}) begin errors++; $display("FAIL wrap_hlt got H%b PC%h want H1 PC1", Halted, PC); end
   endtask

   task automatic test_clear_sta();
      int bad;
      do_clear();
      clear_prog();
      prog[0] = 8'h75; prog[1] = 8'h29; prog[2] = 8'hF0; prog[9] = 8'h44;
      load_prog();
      start_run();
      cyc(5);
      checks++; if ({Running, IR} !== {1'b1, 4'h2}) begin errors++; $display("FAIL csta_in_exec got R%b IR%h want R1 IR2", Running, IR); end
      Clear = 1'b1;
      @(negedge clk);
      Clear = 1'b0;
      checks++; if ({Running, Halted, Zero, Carry} !== 4'b0000) begin errors++; $display("FAIL csta_state got %b want 0000", {Running, Halted, Zero, Carry}); end
      checks++; if ({PC, ACC, IR, MAR, MDO} !== 24'h000000) begin errors++; $display("FAIL csta_regs got %h want 000000", {PC, ACC, IR, MAR, MDO}); end
      bad = 0;
      for (int i = 0; i < 16; i++) if (dut.ram[i] !== mem[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL csta_ram got %0d changed words want 0 (ram9 %h)", bad, dut.ram[9]); end
   endtask

   task automatic test_load_corners();
      int bad;
      do_clear();
      @(negedge clk);
      Mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         LoadWr = 1'b1; DataIn = 8'h10 + 8'(i); mem[i] = DataIn;
         @(negedge clk);
      end
      LoadWr = 1'b1; LoadPtrClr = 1'b1; DataIn = 8'hA5; mem[3] = 8'hA5;
      @(negedge clk);
      LoadWr = 1'b0; LoadPtrClr = 1'b0;
      checks++; if (dut.ram[3] !== 8'hA5) begin errors++; $display("FAIL ld_clrwr_data got %h want a5", dut.ram[3]); end
      checks++; if (MAR !== 4'h0) begin errors++; $display("FAIL ld_clrwr_ptr got %h want 0", MAR); end
      for (int i = 0; i < 15; i++) begin
         LoadWr = 1'b1; DataIn = 8'(i); mem[i] = DataIn;
         @(negedge clk);
      end
      LoadWr = 1'b0;
      checks++; if (MAR !== 4'hF) begin errors++; $display("FAIL ld_ptr15 got %h want f", MAR); end
      LoadWr = 1'b1; DataIn = 8'h5A; mem[15] = 8'h5A;
      @(negedge clk);
      LoadWr = 1'b0;
      checks++; if ({MAR, dut.ram[15]} !== {4'h0, 8'h5A}) begin errors++; $display("FAIL ld_wrap got ptr%h ram%h want ptr0 ram5a", MAR, dut.ram[15]); end
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      checks++; if ({Running, MAR} !== {1'b0, 4'h0}) begin errors++; $display("FAIL ld_start_ignored got R%b ptr%h want R0 ptr0", Running, MAR); end
      start_run();
      Mode = 1'b1; LoadWr = 1'b1; DataIn = 8'hC3;
      cyc(10);
      checks++; if (Running !== 1'b1) begin errors++; $display("FAIL ld_run_stays got %b want 1", Running); end
      LoadWr = 1'b0; Mode = 1'b0;
      bad = 0;
      for (int i = 0; i < 16; i++) if (dut.ram[i] !== mem[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ld_run_nowrite got %0d changed words want 0", bad); end
      do_clear();
   endtask

   task automatic test_random();
      int bad;
      for (int it = 0; it < 6; it++) begin
         do_clear();
         for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
         load_prog();
         model_reset();
         start_run();
         for (int k = 0; k < 30 && !mhalt; k++) begin
            model_step();
            cyc(3);
            checks++;
            if ({PC, ACC, Zero, Carry, Halted} !== {mpc, macc, mz, mc, mhalt}) begin
               errors++;
               $display("FAIL rnd_it%0d_i%0d got PC%h ACC%h Z%b C%b H%b want PC%h ACC%h Z%b C%b H%b",
                        it, k, PC, ACC, Zero, Carry, Halted, mpc, macc, mz, mc, mhalt);
            end
         end
         bad = 0;
         for (int i = 0; i < 16; i++) if (dut.ram[i] !== mem[i]) bad++;
         checks++; if (bad != 0) begin errors++; $display("FAIL rnd_ram_it%0d got %0d differing words want 0", it, bad); end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      model_reset();
      test_reset();
      test_program1();
      test_branch();
      test_sub_borrow();
      test_pc_wrap();
      test_clear_sta();
      test_load_corners();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trisc_core_param.md
Name: trisc_core_param

Overview:
Parametrised, single-clock successor of the 4-bit TRISC processor top.
- Integrates the control FSM, PC, IR, accumulator, ALU, flags and a 2**W-word program/data RAM in one synchronous block.
- Adds zero/carry flags, conditional jumps, a halt state, and a load mode with an auto-incrementing load pointer.
- Sits at board top level, between switches/clock and the seven-segment display drivers.

Parameters:
W, 4, data width = address width; RAM depth 2**W; instruction word 4+W bits (opcode [W+3:W], operand [W-1:0]).

Ports:
SysClock  in  1  sole clock; all state changes on rising edge.
Clear  in  1  synchronous active-high reset.
Start  in  1  level; sampled only in IDLE/HALT with Mode=0; begins execution.
Mode  in  1  0 = run, 1 = load; honoured only in IDLE/HALT.
LoadWr  in  1  one-cycle write strobe in load mode.
LoadPtrClr  in  1  clears load pointer (load mode only).
DataIn  in  4+W  word written by LoadWr.
PC  out  W  program counter.
ACC  out  W  accumulator.
IR  out  4  current opcode.
MAR  out  W  RAM address this cycle.
MDO  out  4+W  RAM read data (registered).
Zero  out  1  zero flag.
Carry  out  1  carry/borrow flag.
Running  out  1  state is FETCH, DECODE or EXEC.
Halted  out  1  state is HALT.

Behaviour:
- Reset (Clear=1 at edge): state IDLE; PC, ACC, IR, load pointer, Zero, Carry = 0; MDO = 0; Running = Halted = 0. RAM contents are not cleared. Clear overrides every other input, including mid-instruction.
- RAM: synchronous; read data valid one edge after the address. Write at MAR on the edge when the write enable is set.
- States and transitions:
  - IDLE/HALT, Mode=1: LoadWr writes DataIn to RAM[ldptr] and increments ldptr, wrapping 2**W-1 -> 0. LoadPtrClr zeroes ldptr; if LoadWr is also set, the write goes to the old address and ldptr becomes 0. Start is ignored. MAR = ldptr.
  - IDLE/HALT, Mode=0, Start=1: PC, ACC, Zero, Carry <= 0; -> FETCH. LoadWr is ignored.
  - FETCH: MAR = PC; -> DECODE.
  - DECODE: IR <= MDO opcode; operand latched; PC <= PC+1, wrapping to 0; MAR = operand; -> EXEC.
  - EXEC: execute; -> FETCH, or HALT for opcode F.
- Every instruction takes exactly 3 cycles. Mode, LoadWr and Start are ignored while Running.
- Opcodes (op = operand; m = RAM[op][W-1:0]):
  - 0 NOP.
  - 1 LDA: ACC<=m.
  - 2 STA: RAM[op] <= {4'h0, ACC}.
  - 3 ADD: {Carry,ACC} <= ACC+m.
  - 4 SUB: ACC <= ACC-m; Carry <= (ACC<m).
  - 5 AND: ACC <= ACC&m.
  - 6 OR: ACC <= ACC|m.
  - 7 LDI: ACC <= op.
  - 8 JMP: PC <= op.
  - 9 JZ: PC <= op if Zero.
  - A JC: PC <= op if Carry.
  - B INC: {Carry,ACC} <= ACC+1.
  - C CLA: ACC <= 0.
  - D NOTA: ACC <= ~ACC.
  - E NOP.
  - F HLT.
- Flags:
  - Zero is updated on opcodes 1, 3-7, B, C, D as (new ACC == 0).
  - Carry is updated only by 3, 4 and B; 5, 6, D and C leave Carry unchanged.
  - Jumps take effect in EXEC; the next FETCH uses the new PC.
  - Arithmetic wraps modulo 2**W.
- Outputs: Running/Halted decode the state register directly.

Decomposition:
- Shared package trisc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, HALT);
  - opcode localparams OP_NOP..OP_HLT;
  - function opcode_field(word).
- One natural sub-module: trisc_alu_param, parameter W, combinational. Inputs ACC, m, op; outputs result, carry_out, carry_we, zero_we.
- RAM is inferred inside the core as an array; no vendor IP.

Test Plan:
1. Load, then run with W=4.
   - Mode=1, LoadWr writes 0x75, 0x38, 0x29, 0xF0 to addresses 0-3, and 0x0C to address 8 (pointer advanced with dummy writes).
   - Mode=0, Start.
   - Expect Halted rises 12 edges after the Start edge; ACC=0x1, Carry=1, Zero=0, RAM[9]=0x01, PC=4.
2. Conditional branch: program LDI 0; JZ 5; LDI 7; HLT at 3; LDI 3 at 5; HLT at 6.
   - Expect ACC=3, PC=7, Halted=1.
3. SUB borrow: LDI 2; SUB a where RAM[a]=3.
   - Expect ACC=0xF, Carry=1, Zero=0.
   - Then INC; expect ACC=0, Carry=1, Zero=1.
4. PC wrap: JMP 0xF with RAM[0xF]=0x00 (NOP), RAM[0]=0xF0.
   - Expect PC goes 0xF -> 0x0, then HLT with PC=1.
5. Clear mid-EXEC of STA.
   - Expect next cycle state IDLE with all registers 0; STA write suppressed; other RAM unchanged.
6. Load-mode corner cases:
   - LoadWr and LoadPtrClr in the same cycle: write lands at the old pointer and the pointer becomes 0.
   - LoadWr with ldptr=0xF: pointer wraps to 0.
   - Start while Mode=1: ignored.
   - LoadWr while Running: no RAM change.
